connect_join: RTL
=================

# connect_join

Many-to-one merge for the packet interconnect, and the converse of `connect_fork`. `CONNECT_NUM` valid/ready sources arbitrate round-robin for one registered output channel. Each accepted packet is forwarded unmodified, with one cycle of latency. The block sits wherever several `echo`-style producers (PE outputs, fork branches) feed a single consumer.

## Interface
Parameters:
- `DATA_WIDTH`, default `PACKET_WIDTH`: packet width in bits.
- `CONNECT_NUM`, default 3: number of sources; must be ≥ 2.

Ports:
- `CLK`  in  1  clock; all state changes on the rising edge.
- `RST`  in  1  reset; synchronous, active-low.
- `RECEIVE_VALID`  in  `CONNECT_NUM`  per-source valid.
- `RECEIVE_READY`  out  `CONNECT_NUM`  per-source ready; at most one bit is high per cycle.
- `RECEIVE_DATA`  in  `DATA_WIDTH*CONNECT_NUM`  flattened; source i occupies `[DATA_WIDTH*(i+1)-1 -: DATA_WIDTH]`.
- `SEND_VALID`  out  1  output valid.
- `SEND_READY`  in  1  output ready.
- `SEND_DATA`  out  `DATA_WIDTH`  output packet.

## Operation
- **Handshake:** a transfer occurs when VALID && READY on a rising edge. Sources hold VALID and DATA stable until accepted. The block holds `SEND_VALID`/`SEND_DATA` stable until `SEND_READY`.
- **Arbitration:** round-robin pointer `ptr` in [0, `CONNECT_NUM`-1].
  - The grant goes to the first asserted `RECEIVE_VALID[j]` scanning j = ptr, ptr+1, … modulo `CONNECT_NUM`.
  - `ptr` advances to (granted index + 1) mod `CONNECT_NUM` only on an accepted transfer. With no transfer, `ptr` is held.
  - Wrap-around: a grant to index `CONNECT_NUM`-1 sets `ptr` = 0.
- **Readiness:** `RECEIVE_READY[g]` is asserted only for the granted index g, and only when the buffer can accept a packet (see Configuration). All other bits are 0.
- **Buffer write:** an accepted packet is written to the output buffer. Packets are never duplicated, dropped or reordered within one source.
- **Fairness:** a source that holds VALID is accepted within `CONNECT_NUM` accepted transfers.
- **Simultaneous accept and drain (buffer full, `SEND_READY`=1):**
  - base build: the new packet replaces the drained one in the same edge.
  - skid build: occupancy stays unchanged.
- **Reset:** while `RST`=0, all `RECEIVE_READY`=0, `SEND_VALID`=0, buffer emptied, `ptr`=0. Reset asserted mid-operation discards any buffered packet. No transfer completes on an edge where `RST`=0.

## Timing
- Latency from accept edge to `SEND_VALID`=1: 1 cycle, registered. `SEND_DATA` is registered.
- Throughput: 1 packet/cycle while `SEND_READY`=1.
- Base build: `RECEIVE_READY` is combinational from `RECEIVE_VALID`, `ptr`, buffer-full and `SEND_READY`.
- No combinational path from `RECEIVE_*` to `SEND_VALID`/`SEND_DATA`.
- First cycle after reset release: `RECEIVE_READY` may assert for a valid source; `SEND_VALID` is 0.

## Configuration
- `CONNECT_JOIN_SKID_EN` defined:
  - 2-entry FIFO output buffer.
  - `RECEIVE_READY[g]` = grant && (occupancy < 2), purely from registered state. This removes the `SEND_READY`→`RECEIVE_READY` combinational path.
  - Full throughput is kept.
- Undefined:
  - 1-entry output register.
  - `RECEIVE_READY[g]` = grant && (empty || `SEND_READY`).

## Structure
- Shared `include/param.vh` holds `PACKET_WIDTH`. Testbench handshake tasks come from `include/macro.vh`.
- Sub-module `arbiter_rr`:
  - parameter `NUM`.
  - inputs `CLK`, `RST`, `REQ[NUM-1:0]`, `ACCEPT`.
  - output one-hot `GRANT[NUM-1:0]`.
  - owns `ptr`.
- `connect_join` owns the buffer, the mux and the ready gating.

## Test plan
- **Reset:** hold `RST`=0 for 1 cycle with all sources valid -> `SEND_VALID`=0 and `RECEIVE_READY`=3'b000. After release, `ptr`=0.
- **All-valid order:** sources 0, 1, 2 valid simultaneously with packets A, B, C and `SEND_READY`=1 -> output order A, B, C on consecutive cycles, and `RECEIVE_READY` one-hot 001, 010, 100.
- **Backpressure:** `SEND_READY`=0 for 5 cycles with source 1 valid (packet D) ->
  - `SEND_DATA`=D held stable and `SEND_VALID`=1 throughout.
  - Further sources stall: one more accepted in the skid build, none in the base build.
  - Release -> no loss or duplication.
- **Wrap-around:** grant source 2, then sources 0 and 2 valid -> source 0 granted next (`ptr` wrapped 2→0).
- **Fairness under load:** source 0 always valid, sources 1 and 2 valid 50% of the time, random `SEND_READY`, 1000 packets ->
  - per-source order preserved.
  - no source waits more than 3 accepted transfers.
  - scoreboard count equal.
- **Reset mid-operation:** buffer full with packet E, assert `RST`=0 for 1 cycle -> E never appears on `SEND_DATA`, `SEND_VALID`=0 the next cycle, and `ptr`=0.

Source files
------------

// File: rtl/connect_join_pkg.sv
// connect_join shared types: packet width and round-robin helpers.
// Optional build macro used by connect_join: CONNECT_JOIN_SKID_EN.
package connect_join_pkg;

  localparam int PACKET_WIDTH = 32;

  function automatic int rr_next(input int idx, input int num);
    return (idx == num - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/connect_join_arbiter_rr.sv
// Round-robin arbiter: one-hot grant scanning upward from ptr.
// ptr moves past the winner only when the grant is accepted.
module arbiter_rr
  import connect_join_pkg::*;
#(
  parameter int NUM = 3
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic [NUM-1:0] REQ,
  input  logic           ACCEPT,
  output logic [NUM-1:0] GRANT
);

  localparam int PW = (NUM > 1) ? $clog2(NUM) : 1;

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_idx;
  logic          w_hit;

  // Two passes: indices at/above ptr first, then the wrapped tail.
  always_comb begin
    GRANT = '0;
    w_idx = '0;
    w_hit = 1'b0;
    for (int j = 0; j < NUM; j++) begin
      if (!w_hit && REQ[j] && j >= int'(r_ptr)) begin
        w_hit    = 1'b1;
        w_idx    = PW'(j);
        GRANT[j] = 1'b1;
      end
    end
    for (int j = 0; j < NUM; j++) begin
      if (!w_hit && REQ[j] && j < int'(r_ptr)) begin
        w_hit    = 1'b1;
        w_idx    = PW'(j);
        GRANT[j] = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_ptr <= '0;
    end else if (ACCEPT && w_hit) begin
      r_ptr <= PW'(rr_next(int'(w_idx), NUM));
    end
  end

endmodule

// File: rtl/connect_join.sv
// Many-to-one round-robin merge onto one registered output channel.
// Define CONNECT_JOIN_SKID_EN for a 2-entry output FIFO.
module connect_join
  import connect_join_pkg::*;
#(
  parameter int DATA_WIDTH  = PACKET_WIDTH,
  parameter int CONNECT_NUM = 3
) (
  input  logic                            CLK,
  input  logic                            RST,
  input  logic [CONNECT_NUM-1:0]          RECEIVE_VALID,
  output logic [CONNECT_NUM-1:0]          RECEIVE_READY,
  input  logic [DATA_WIDTH*CONNECT_NUM-1:0] RECEIVE_DATA,
  output logic                            SEND_VALID,
  input  logic                            SEND_READY,
  output logic [DATA_WIDTH-1:0]           SEND_DATA
);

  logic [CONNECT_NUM-1:0] w_grant;
  logic                   w_space;
  logic                   w_accept;
  logic [DATA_WIDTH-1:0]  w_mux;

  arbiter_rr #(
    .NUM(CONNECT_NUM)
  ) u_arb (
    .CLK   (CLK),
    .RST   (RST),
    .REQ   (RECEIVE_VALID),
    .ACCEPT(w_accept),
    .GRANT (w_grant)
  );

  always_comb begin
    w_mux = '0;
    for (int i = 0; i < CONNECT_NUM; i++) begin
      if (w_grant[i]) begin
        w_mux |= RECEIVE_DATA[DATA_WIDTH*i +: DATA_WIDTH];
      end
    end
  end

  assign RECEIVE_READY = w_grant & {CONNECT_NUM{w_space & RST}};
  assign w_accept      = |(RECEIVE_VALID & RECEIVE_READY);

`ifdef CONNECT_JOIN_SKID_EN
  logic [DATA_WIDTH-1:0] r_mem [2];
  logic                  r_wr;
  logic                  r_rd;
  logic [1:0]            r_cnt;
  logic                  w_pop;

  // Space depends only on registered occupancy, not on SEND_READY.
  assign w_space    = (r_cnt != 2'd2);
  assign w_pop      = (r_cnt != 2'd0) && SEND_READY;
  assign SEND_VALID = (r_cnt != 2'd0);
  assign SEND_DATA  = r_mem[r_rd];

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_wr     <= 1'b0;
      r_rd     <= 1'b0;
      r_cnt    <= 2'd0;
      r_mem[0] <= '0;
      r_mem[1] <= '0;
    end else begin
      if (w_accept) begin
        r_mem[r_wr] <= w_mux;
        r_wr        <= ~r_wr;
      end
      if (w_pop) begin
        r_rd <= ~r_rd;
      end
      r_cnt <= r_cnt + {1'b0, w_accept} - {1'b0, w_pop};
    end
  end
`else
  logic                  r_vld;
  logic [DATA_WIDTH-1:0] r_data;

  assign w_space    = !r_vld || SEND_READY;
  assign SEND_VALID = r_vld;
  assign SEND_DATA  = r_data;

  // Accept while full and draining overwrites in the same edge.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_vld  <= 1'b0;
      r_data <= '0;
    end else if (w_accept) begin
      r_vld  <= 1'b1;
      r_data <= w_mux;
    end else if (SEND_READY) begin
      r_vld  <= 1'b0;
    end
  end
`endif

endmodule
